// File: rtl/key_schedule_if.sv
// rtl/key_schedule_if.sv - round-key request/delivery bus between cipher datapath and key schedule
interface key_schedule_if;
    logic [79:0] key_i;
    logic        load_i;
    logic        ready_o;
    logic        abort_i;
    logic        next_i;
    logic [63:0] round_key_o;
    logic        round_key_valid_o;
    logic [5:0]  round_idx_o;
    logic        last_o;

    // Datapath side: issues load/next/abort and consumes round keys
    modport master (
        output key_i,
        output load_i,
        output abort_i,
        output next_i,
        input  ready_o,
        input  round_key_o,
        input  round_key_valid_o,
        input  round_idx_o,
        input  last_o
    );

    // Key schedule side
    modport slave (
        input  key_i,
        input  load_i,
        input  abort_i,
        input  next_i,
        output ready_o,
        output round_key_o,
        output round_key_valid_o,
        output round_idx_o,
        output last_o
    );
endinterface

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - PRESENT-80 key register, round counter and round-key handshake
module key_update (
    input  logic [79:0] data_i,
    input  logic [4:0]  round_counter,
    output logic [79:0] data_o
);
    logic [79:0] w_rot;
    logic [3:0]  w_sbox_out;

    // Rotate left by 61, substitute the top nibble, fold the round counter into bits 19:15
    always_comb begin
        w_rot = {data_i[18:0], data_i[79:19]};
        case (w_rot[79:76])
            4'h0: w_sbox_out = 4'hC;
            4'h1: w_sbox_out = 4'h5;
            4'h2: w_sbox_out = 4'h6;
            4'h3: w_sbox_out = 4'hB;
            4'h4: w_sbox_out = 4'h9;
            4'h5: w_sbox_out = 4'h0;
            4'h6: w_sbox_out = 4'hA;
            4'h7: w_sbox_out = 4'hD;
            4'h8: w_sbox_out = 4'h3;
            4'h9: w_sbox_out = 4'hE;
            4'hA: w_sbox_out = 4'hF;
            4'hB: w_sbox_out = 4'h8;
            4'hC: w_sbox_out = 4'h4;
            4'hD: w_sbox_out = 4'h7;
            4'hE: w_sbox_out = 4'h1;
            default: w_sbox_out = 4'h2;
        endcase
        data_o = {w_sbox_out, w_rot[75:20], w_rot[19:15] ^ round_counter, w_rot[14:0]};
    end
endmodule

module key_schedule #(
    parameter int NUM_ROUNDS = 31
) (
    input  logic          clk,
    input  logic          rst,
    key_schedule_if.slave bus
);
    // Terminal counter value: the whitening key, never fed to an update
    localparam logic [5:0] LP_LAST_IDX = 6'(NUM_ROUNDS + 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [79:0] r_key_reg;
    logic [79:0] w_key_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [79:0] w_upd_key;
    logic        w_valid;

    key_update u_key_update (
        .data_i        (r_key_reg),
        .round_counter (r_cnt[4:0]),
        .data_o        (w_upd_key)
    );

    // State, key register and counter; reset and abort both zeroize the key material
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_key_reg <= 80'd0;
            r_cnt     <= 6'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_key_reg <= w_key_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state decode: abort wins, loads only in IDLE, next steps or retires the sequence
    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key_reg;
        w_cnt_nxt   = r_cnt;
        if (bus.abort_i) begin
            w_state_nxt = ST_IDLE;
            w_key_nxt   = 80'd0;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_i) begin
                        w_state_nxt = ST_ACTIVE;
                        w_key_nxt   = bus.key_i;
                        w_cnt_nxt   = 6'd1;
                    end
                end
                default: begin
                    if (bus.next_i) begin
                        if (r_cnt == LP_LAST_IDX) begin
                            w_state_nxt = ST_IDLE;
                            w_key_nxt   = 80'd0;
                            w_cnt_nxt   = 6'd0;
                        end else begin
                            w_key_nxt   = w_upd_key;
                            w_cnt_nxt   = r_cnt + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs decode from registers only, so next_i has no combinational path to them
    always_comb begin
        w_valid               = (r_state == ST_ACTIVE);
        bus.ready_o           = (r_state == ST_IDLE);
        bus.round_key_valid_o = w_valid;
        bus.round_key_o       = w_valid ? r_key_reg[79:16] : 64'd0;
        bus.round_idx_o       = w_valid ? r_cnt : 6'd0;
        bus.last_o            = w_valid && (r_cnt == LP_LAST_IDX);
    end
endmodule
